mc_ctrl: RTL and testbench

Multi-cycle control FSM for the MIPS-subset CPU. It sequences fetch, decode, execute, memory and write-back, and drives the PC write enable and next-PC select. It also drives the register-file, ALU and memory controls, and performs a req/ready handshake with instruction and data memory. It replaces the single-cycle decode so that the PC and datapath are shared across cycles.

---
 rtl/mc_ctrl_pkg.sv | 64 ++++++
 rtl/mc_ctrl_decode.sv | 66 ++++++
 rtl/mc_ctrl.sv | 156 +++++++++++++++
 tb/tb_mc_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset control FSM.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExe    = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        ClsUnknown = 3'd0,
        ClsAlu     = 3'd1,
        ClsLw      = 3'd2,
        ClsSw      = 3'd3,
        ClsBeq     = 3'd4,
        ClsJal     = 3'd5,
        ClsJr      = 3'd6
    } cls_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpLui   = 6'b001111;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJal   = 6'b000011;

    localparam logic [5:0] FunctAddu = 6'b100001;
    localparam logic [5:0] FunctSubu = 6'b100011;
    localparam logic [5:0] FunctJr   = 6'b001000;

    localparam logic [2:0] NpcPc4    = 3'b000;
    localparam logic [2:0] NpcBranch = 3'b001;
    localparam logic [2:0] NpcJal    = 3'b010;
    localparam logic [2:0] NpcJr     = 3'b011;

    localparam logic [1:0] DstRt = 2'b00;
    localparam logic [1:0] DstRd = 2'b01;
    localparam logic [1:0] DstRa = 2'b10;

    localparam logic [1:0] WdAlu = 2'b00;
    localparam logic [1:0] WdMem = 2'b01;
    localparam logic [1:0] WdPc4 = 2'b10;

    localparam logic [1:0] ExtZero  = 2'b00;
    localparam logic [1:0] ExtSign  = 2'b01;
    localparam logic [1:0] ExtUpper = 2'b10;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluOr  = 3'b010;

    typedef struct packed {
        cls_e       cls;
        logic [1:0] reg_dst;
        logic [1:0] wd_sel;
        logic       alu_src;
        logic [1:0] ext_op;
        logic [2:0] alu_op;
    } dec_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction classifier: op/funct to class and datapath selects.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output dec_t       dec
);

    always_comb begin
        dec     = '0;
        dec.cls = ClsUnknown;
        case (op)
            OpRtype: begin
                case (funct)
                    FunctAddu: begin
                        dec.cls     = ClsAlu;
                        dec.reg_dst = DstRd;
                        dec.alu_op  = AluAdd;
                    end
                    FunctSubu: begin
                        dec.cls     = ClsAlu;
                        dec.reg_dst = DstRd;
                        dec.alu_op  = AluSub;
                    end
                    FunctJr: dec.cls = ClsJr;
                    default: dec.cls = ClsUnknown;
                endcase
            end
            OpOri: begin
                dec.cls     = ClsAlu;
                dec.alu_src = 1'b1;
                dec.ext_op  = ExtZero;
                dec.alu_op  = AluOr;
            end
            OpLui: begin
                dec.cls     = ClsAlu;
                dec.alu_src = 1'b1;
                dec.ext_op  = ExtUpper;
                dec.alu_op  = AluAdd;
            end
            OpLw: begin
                dec.cls     = ClsLw;
                dec.alu_src = 1'b1;
                dec.ext_op  = ExtSign;
                dec.wd_sel  = WdMem;
            end
            OpSw: begin
                dec.cls     = ClsSw;
                dec.alu_src = 1'b1;
                dec.ext_op  = ExtSign;
            end
            OpBeq: begin
                dec.cls    = ClsBeq;
                dec.alu_op = AluSub;
            end
            OpJal: begin
                dec.cls     = ClsJal;
                dec.reg_dst = DstRa;
                dec.wd_sel  = WdPc4;
            end
            default: dec.cls = ClsUnknown;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM: fetch/decode/execute/memory/write-back sequencing.
// Optional retired-instruction counter enabled by defining MC_CTRL_PERF_EN.
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic [2:0]  npc_sel,
    output logic        reg_we,
    output logic [1:0]  reg_dst,
    output logic [1:0]  wd_sel,
    output logic        alu_src,
    output logic [1:0]  ext_op,
    output logic [2:0]  alu_op
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0] instr_cnt
`endif
);

    state_e     state_q, state_d;
    logic       imem_req_q, imem_req_d;
    logic       dmem_req_q, dmem_req_d;
    logic       dmem_we_q, dmem_we_d;
    logic       reg_we_q, reg_we_d;
    logic       retire;
    logic [2:0] npc_c;
    logic       active;
    dec_t       dec;

    mc_ctrl_decode u_decode (
        .op    (op),
        .funct (funct),
        .dec   (dec)
    );

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        npc_c   = NpcPc4;
        unique case (state_q)
            StFetch: if (imem_ready) state_d = StDecode;
            StDecode: begin
                case (dec.cls)
                    ClsJal:     state_d = StWb;
                    ClsUnknown: begin
                        retire  = 1'b1;
                        state_d = StFetch;
                    end
                    default:    state_d = StExe;
                endcase
            end
            StExe: begin
                case (dec.cls)
                    ClsAlu:       state_d = StWb;
                    ClsLw, ClsSw: state_d = StMem;
                    ClsBeq: begin
                        retire  = 1'b1;
                        npc_c   = zero ? NpcBranch : NpcPc4;
                        state_d = StFetch;
                    end
                    ClsJr: begin
                        retire  = 1'b1;
                        npc_c   = NpcJr;
                        state_d = StFetch;
                    end
                    default:      state_d = StFetch;
                endcase
            end
            StMem: begin
                if (dmem_ready) begin
                    if (dec.cls == ClsLw) begin
                        state_d = StWb;
                    end else begin
                        retire  = 1'b1;
                        state_d = StFetch;
                    end
                end
            end
            StWb: begin
                retire  = 1'b1;
                npc_c   = (dec.cls == ClsJal) ? NpcJal : NpcPc4;
                state_d = StFetch;
            end
            default: state_d = StFetch;
        endcase

        // Request/write strobes are registered from the next state so they are glitch-free.
        imem_req_d = (state_d == StFetch);
        dmem_req_d = (state_d == StMem);
        dmem_we_d  = (state_d == StMem) && (dec.cls == ClsSw);
        reg_we_d   = (state_d == StWb);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StFetch;
            imem_req_q <= 1'b1;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            reg_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            imem_req_q <= imem_req_d;
            dmem_req_q <= dmem_req_d;
            dmem_we_q  <= dmem_we_d;
            reg_we_q   <= reg_we_d;
        end
    end

    // A reset cycle aborts the instruction in flight, so commit strobes are masked.
    always_comb begin
        active   = (state_q != StFetch);
        imem_req = imem_req_q;
        dmem_req = dmem_req_q;
        dmem_we  = dmem_we_q;
        reg_we   = reg_we_q && !reset;
        pc_we    = retire && !reset;
        ir_we    = (state_q == StFetch) && imem_ready && !reset;
        npc_sel  = pc_we ? npc_c : NpcPc4;
        reg_dst  = active ? dec.reg_dst : 2'b00;
        wd_sel   = active ? dec.wd_sel : 2'b00;
        alu_src  = active ? dec.alu_src : 1'b0;
        ext_op   = active ? dec.ext_op : 2'b00;
        alu_op   = active ? dec.alu_op : 3'b000;
    end

`ifdef MC_CTRL_PERF_EN
    logic [31:0] instr_cnt_q, instr_cnt_d;

    always_comb begin
        instr_cnt_d = pc_we ? instr_cnt_q + 32'd1 : instr_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_cnt_q <= 32'd0;
        end else begin
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: stimulus pushes expected retirements, a monitor checks them.
module tb_mc_ctrl;

    logic        clk;
    logic        reset;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        imem_ready;
    logic        dmem_ready;
    logic        imem_req;
    logic        dmem_req;
    logic        dmem_we;
    logic        ir_we;
    logic        pc_we;
    logic [2:0]  npc_sel;
    logic        reg_we;
    logic [1:0]  reg_dst;
    logic [1:0]  wd_sel;
    logic        alu_src;
    logic [1:0]  ext_op;
    logic [2:0]  alu_op;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] instr_cnt;
`endif

    mc_ctrl u_dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .imem_req   (imem_req),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .npc_sel    (npc_sel),
        .reg_we     (reg_we),
        .reg_dst    (reg_dst),
        .wd_sel     (wd_sel),
        .alu_src    (alu_src),
        .ext_op     (ext_op),
        .alu_op     (alu_op)
`ifdef MC_CTRL_PERF_EN
        ,
        .instr_cnt  (instr_cnt)
`endif
    );

    typedef struct packed {
        int id;
        int t0;
        int len;
        int npc;
        int we;
        int dst;
        int wd;
        int src;
        int ext;
        int alu;
        int mwe;
        int dcyc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc_now = 0;
    int   nid = 0;
    int   n_ret = 0;
    bit   stim_done = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_now <= cyc_now + 1;

    task automatic chk(input string nm, input int id, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s (item %0d): got %0d expected %0d", nm, id, act, exp);
        end
    endtask

    function automatic exp_t mk(input int len, npc, we, dst, wd, src, ext, alu, mwe, dcyc);
        exp_t e;
        e = '{id: 0, t0: 0, len: len, npc: npc, we: we, dst: dst, wd: wd, src: src, ext: ext,
              alu: alu, mwe: mwe, dcyc: dcyc};
        return e;
    endfunction

    task automatic monitor();
        exp_t e;
        int   dcnt = 0;
        while (!stim_done) begin
            @(negedge clk);
            if (reset) dcnt = 0;
            else if (dmem_req) dcnt++;
            if (pc_we) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pc_we", -1, 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("cycles", e.id, cyc_now - e.t0 + 1, e.len);
                    chk("npc_sel", e.id, int'(npc_sel), e.npc);
                    chk("reg_we", e.id, int'(reg_we), e.we);
                    chk("reg_dst", e.id, int'(reg_dst), e.dst);
                    chk("wd_sel", e.id, int'(wd_sel), e.wd);
                    chk("alu_src", e.id, int'(alu_src), e.src);
                    chk("ext_op", e.id, int'(ext_op), e.ext);
                    chk("alu_op", e.id, int'(alu_op), e.alu);
                    chk("dmem_we", e.id, int'(dmem_we), e.mwe);
                    chk("dmem_req_cycles", e.id, dcnt, e.dcyc);
                end
                dcnt = 0;
            end
        end
    endtask

    // Entered at posedge+1 of the instruction's first (FETCH) cycle; returns likewise.
    task automatic run(input logic [5:0] o, input logic [5:0] f, input logic z, input int iw,
                       input int dw, input logic junk, input exp_t e);
        int n = 0;
        bit done;
        op    = o;
        funct = f;
        zero  = z;
        e.t0  = cyc_now;
        e.id  = nid;
        nid++;
        n_ret++;
        sb.push_back(e);
        forever begin
            imem_ready = imem_req ? (iw == 0) : junk;
            if (imem_req && iw > 0) iw--;
            dmem_ready = dmem_req ? (dw == 0) : junk;
            if (dmem_req && dw > 0) dw--;
            @(negedge clk);
            #1;
            done = (sb.size() == 0);
            @(posedge clk);
            #1;
            if (done) break;
            n++;
            if (n > 100) begin
                chk("timeout", e.id, n, 0);
                sb.delete();
                break;
            end
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic stimulus();
        op = 6'd0; funct = 6'd0; zero = 1'b0;
        do_reset();
        n_ret = 0;
        @(negedge clk);
        chk("rst_imem_req", -1, int'(imem_req), 1);
        chk("rst_dmem_req", -1, int'(dmem_req), 0);
        chk("rst_dmem_we", -1, int'(dmem_we), 0);
        chk("rst_ir_we", -1, int'(ir_we), 0);
        chk("rst_pc_we", -1, int'(pc_we), 0);
        chk("rst_reg_we", -1, int'(reg_we), 0);
        chk("rst_npc_sel", -1, int'(npc_sel), 0);
        chk("rst_selects", -1, int'({reg_dst, wd_sel, alu_src, ext_op, alu_op}), 0);
`ifdef MC_CTRL_PERF_EN
        chk("rst_instr_cnt", -1, int'(instr_cnt), 0);
`endif
        @(posedge clk);
        #1;
        //  op       funct      z  iw dw junk     len npc we dst wd src ext alu mwe dcyc
        run(6'h00, 6'b100001, 0, 0, 0, 0, mk(4, 0, 1, 1, 0, 0, 0, 0, 0, 0));  // addu
        run(6'h00, 6'b100011, 0, 2, 0, 1, mk(6, 0, 1, 1, 0, 0, 0, 1, 0, 0));  // subu, fetch wait
        run(6'h0d, 6'b000000, 0, 0, 0, 0, mk(4, 0, 1, 0, 0, 1, 0, 2, 0, 0));  // ori
        run(6'h0f, 6'b000000, 0, 0, 0, 0, mk(4, 0, 1, 0, 0, 1, 2, 0, 0, 0));  // lui
        run(6'h23, 6'b000000, 0, 0, 3, 0, mk(8, 0, 1, 0, 1, 1, 1, 0, 0, 4));  // lw, 3 waits
        run(6'h2b, 6'b000000, 0, 0, 0, 1, mk(4, 0, 0, 0, 0, 1, 1, 0, 1, 1));  // sw
        run(6'h04, 6'b000000, 1, 0, 0, 0, mk(3, 1, 0, 0, 0, 0, 0, 1, 0, 0));  // beq taken
        run(6'h04, 6'b000000, 0, 0, 0, 0, mk(3, 0, 0, 0, 0, 0, 0, 1, 0, 0));  // beq not taken
        run(6'h03, 6'b000000, 0, 0, 0, 0, mk(3, 2, 1, 2, 2, 0, 0, 0, 0, 0));  // jal
        run(6'h00, 6'b001000, 0, 0, 0, 0, mk(3, 3, 0, 0, 0, 0, 0, 0, 0, 0));  // jr
        run(6'h00, 6'b000000, 0, 0, 0, 0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0));  // nop
        run(6'h3f, 6'b000000, 0, 0, 0, 1, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0));  // unknown op
        run(6'h00, 6'b100000, 0, 0, 0, 0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0));  // unknown funct
`ifdef MC_CTRL_PERF_EN
        chk("instr_cnt_run", -1, int'(instr_cnt), n_ret);
`endif

        // sw stalled in MEM, aborted by a reset pulse while dmem_ready is high.
        op = 6'h2b; funct = 6'd0; imem_ready = 1'b1; dmem_ready = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            imem_ready = 1'b0;
        end
        @(negedge clk);
        chk("abort_dmem_req", -1, int'(dmem_req), 1);
        chk("abort_dmem_we", -1, int'(dmem_we), 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        dmem_ready = 1'b1;
        @(negedge clk);
        chk("abort_pc_we", -1, int'(pc_we), 0);
        chk("abort_reg_we", -1, int'(reg_we), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        dmem_ready = 1'b0;
        @(negedge clk);
        chk("abort_dmem_req_drop", -1, int'(dmem_req), 0);
        chk("abort_fetch", -1, int'(imem_req), 1);
`ifdef MC_CTRL_PERF_EN
        chk("abort_instr_cnt", -1, int'(instr_cnt), 0);
`endif
        @(posedge clk);
        #1;
        n_ret = 0;
        run(6'h00, 6'b100001, 0, 0, 0, 0, mk(4, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        run(6'h3e, 6'b000000, 0, 0, 0, 0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        run(6'h04, 6'b000000, 1, 0, 0, 0, mk(3, 1, 0, 0, 0, 0, 0, 1, 0, 0));
        run(6'h03, 6'b000000, 0, 0, 0, 0, mk(3, 2, 1, 2, 2, 0, 0, 0, 0, 0));
        run(6'h23, 6'b000000, 0, 0, 0, 0, mk(5, 0, 1, 0, 1, 1, 1, 0, 0, 1));
        run(6'h0d, 6'b000000, 0, 1, 0, 0, mk(5, 0, 1, 0, 0, 1, 0, 2, 0, 0));
`ifdef MC_CTRL_PERF_EN
        chk("instr_cnt_six", -1, int'(instr_cnt), 6);
`endif
        chk("scoreboard_empty", -1, sb.size(), 0);
        stim_done = 1'b1;
    endtask

    initial begin
        fork
            monitor();
            stimulus();
        join
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
